// File: rtl/mul_pkg.sv
// Shared types and widths for the multiplier issue controller.
// Holds the FSM state enum, datapath widths and the result bundle.
package mul_pkg;

    localparam int OP_W      = 32;
    localparam int PROD_W    = 64;
    localparam int LZ_W      = 5;
    // Tag field is sized for the widest caller tag we expect;
    // narrower tags are zero-extended into it.
    localparam int TAG_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ARM,
        WAIT
    } state_t;

    typedef struct packed {
        logic [PROD_W-1:0]    product;
        logic [TAG_MAX_W-1:0] tag;
        logic [LZ_W-1:0]      lz_a;
        logic [LZ_W-1:0]      lz_b;
        logic                 err;
    } result_t;

endpackage

// File: rtl/mul_operand_fifo.sv
// Synchronous FIFO buffering operand pairs ahead of the multiplier.
// Ports: push/wdata/full (write side), pop/rdata/empty (read side).
module mul_operand_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 68
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;
    logic         do_push;
    logic         do_pop;

    // Wrap bits differ with equal indices => full.
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty = (wr_q == rd_q);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/mul_issue_ctrl.sv
// Issues buffered signed operand pairs one at a time to the multiplier
// and returns product/tag/lz on a result stream, with timeout retire.
// Ports: in_* (operand stream), out_* (result stream),
// mul_* (multiplier handshake), timeout_seen, busy.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 100
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_product,
    output logic [TAG_W-1:0]  out_tag,
    output logic [LZ_W-1:0]   out_lz_a,
    output logic [LZ_W-1:0]   out_lz_b,
    output logic              out_err,
    output logic              mul_start,
    output logic [OP_W-1:0]   mul_operand_a,
    output logic [OP_W-1:0]   mul_operand_b,
    input  logic              mul_done,
    input  logic [PROD_W-1:0] mul_product,
    input  logic [LZ_W-1:0]   mul_lz_a,
    input  logic [LZ_W-1:0]   mul_lz_b,
    output logic              timeout_seen,
    output logic              busy
);

    localparam int FW    = 2*OP_W + TAG_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state_q;
    state_t           state_d;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [FW-1:0]    head;
    logic [OP_W-1:0]  head_a;
    logic [OP_W-1:0]  head_b;
    logic [TAG_W-1:0] head_tag;
    logic [TAG_W-1:0] tag_q;
    logic [CNT_W-1:0] cnt_q;
    logic             timed_out;
    logic             capture;
    logic             slot_free;
    logic             valid_q;
    logic             seen_q;
    result_t          res_q;

    mul_operand_fifo #(
        .DEPTH (DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .wdata ({in_a, in_b, in_tag}),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign {head_a, head_b, head_tag} = head;

    // A result leaving this cycle frees the slot for the next issue.
    assign slot_free = !valid_q || out_ready;
    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign capture   = (state_q == WAIT) && (mul_done || timed_out);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && slot_free) begin
                    state_d = ISSUE;
                    pop     = 1'b1;
                end
            end
            ISSUE: state_d = ARM;
            // done is ignored here: it may still be high from the
            // previous operation.
            ARM:   state_d = WAIT;
            WAIT: begin
                if (mul_done || timed_out) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            mul_operand_a <= '0;
            mul_operand_b <= '0;
            tag_q         <= '0;
            cnt_q         <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                mul_operand_a <= head_a;
                mul_operand_b <= head_b;
                tag_q         <= head_tag;
            end
            if (state_q == ARM) begin
                cnt_q <= '0;
            end else if (state_q == WAIT && !mul_done && !timed_out) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            seen_q  <= 1'b0;
            res_q   <= '0;
        end else if (capture) begin
            valid_q   <= 1'b1;
            res_q.tag <= TAG_MAX_W'(tag_q);
            if (mul_done) begin
                res_q.product <= mul_product;
                res_q.lz_a    <= mul_lz_a;
                res_q.lz_b    <= mul_lz_b;
                res_q.err     <= 1'b0;
            end else begin
                res_q.product <= '0;
                res_q.lz_a    <= '0;
                res_q.lz_b    <= '0;
                res_q.err     <= 1'b1;
                seen_q        <= 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign in_ready     = !fifo_full;
    assign mul_start    = (state_q == ISSUE);
    assign out_valid    = valid_q;
    assign out_product  = res_q.product;
    assign out_tag      = TAG_W'(res_q.tag);
    assign out_lz_a     = res_q.lz_a;
    assign out_lz_b     = res_q.lz_b;
    assign out_err      = res_q.err;
    assign timeout_seen = seen_q;
    assign busy         = (state_q != IDLE) || !fifo_empty;

endmodule
